// File: rtl/loom_scan_mem.sv
// Depth x Width register memory with a functional read/write port and a
// serial scan chain that rotates through every word, word 0 MSB first.
module loom_scan_mem #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    input  logic                     loom_scan_enable,
    input  logic                     loom_scan_in,
    output logic                     loom_scan_out
);

    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Width);
    localparam logic [AW-1:0] WORD_LAST = AW'(Depth - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(Width - 1);

    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] sh;
    logic [CW-1:0]    bit_cnt;
    logic [AW-1:0]    word_idx;

    logic [Width-1:0] shifted;
    logic [AW-1:0]    next_idx;
    logic             func_wr;
    logic             func_rd;
    logic             fwd_wr;

    always_comb begin
        shifted  = {sh[Width-2:0], loom_scan_in};
        next_idx = (word_idx == WORD_LAST) ? '0 : word_idx + AW'(1);
        func_wr  = en_i && we_i;
        func_rd  = en_i && !we_i;
        fwd_wr   = func_wr && (addr_i == '0);
    end

    assign loom_scan_out = sh[Width-1];

    // While idle, sh keeps a fresh copy of word 0 so a scan can start on its
    // very first cycle without a load bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the array is cleared on reset because reset must leave
            // every stored word at zero, not just the control state.
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            sh       <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            rdata_o  <= '0;
        end else if (loom_scan_enable) begin
            if (bit_cnt == BIT_LAST) begin
                mem[word_idx] <= shifted;
                sh            <= mem[next_idx];
                bit_cnt       <= '0;
                word_idx      <= next_idx;
            end else begin
                sh      <= shifted;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end else begin
            if (func_wr) begin
                mem[addr_i] <= wdata_i;
            end
            if (func_rd) begin
                rdata_o <= mem[addr_i];
            end
            sh       <= fwd_wr ? wdata_i : mem[0];
            bit_cnt  <= '0;
            word_idx <= '0;
        end
    end

endmodule

// File: tb/tb_loom_scan_mem.sv
// Scoreboard bench for loom_scan_mem (Depth=4, Width=8): stimulus queues the
// expected read data and scan-out bits, a monitor consumes them as they appear.
module tb_loom_scan_mem;

    localparam int Depth = 4;
    localparam int Width = 8;

    typedef enum logic {K_READ, K_SCAN} kind_e;
    typedef struct {
        kind_e       kind;
        logic [7:0]  value;
        string       name;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       we_i;
    logic [1:0] addr_i;
    logic [7:0] wdata_i;
    logic [7:0] rdata_o;
    logic       loom_scan_enable;
    logic       loom_scan_in;
    logic       loom_scan_out;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_pending = 1'b0;

    loom_scan_mem #(.Depth(Depth), .Width(Width)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .rdata_o          (rdata_o),
        .loom_scan_enable (loom_scan_enable),
        .loom_scan_in     (loom_scan_in),
        .loom_scan_out    (loom_scan_out)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: a read launched at one edge is visible at the following negedge;
    // a scan-out bit is visible during every cycle the scan enable is high.
    always @(negedge clk_i) begin
        exp_t e;
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                check("read_unexpected", rdata_o, 8'hxx);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != K_READ) check({e.name, "_kind"}, 8'd0, 8'd1);
                else                  check(e.name, rdata_o, e.value);
            end
        end
        if (rst_ni && loom_scan_enable) begin
            if (exp_q.size() == 0) begin
                check("scan_unexpected", {7'd0, loom_scan_out}, 8'hxx);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != K_SCAN) check({e.name, "_kind"}, 8'd1, 8'd0);
                else                  check(e.name, {7'd0, loom_scan_out}, e.value);
            end
        end
        rd_pending = rst_ni && en_i && !we_i && !loom_scan_enable;
    end

    task automatic drive_idle();
        @(posedge clk_i); #1;
        en_i = 1'b0; we_i = 1'b0; loom_scan_enable = 1'b0; loom_scan_in = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk_i); #1;
        en_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; loom_scan_enable = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] expected, input string name);
        exp_t e;
        @(posedge clk_i); #1;
        en_i = 1'b1; we_i = 1'b0; addr_i = a; loom_scan_enable = 1'b0;
        e.kind = K_READ; e.value = expected; e.name = name;
        exp_q.push_back(e);
    endtask

    // Shift n bits; in_bits and out_bits are listed MSB-first (bit n-1 first).
    task automatic scan(input int n, input logic [63:0] in_bits, input logic [63:0] out_bits,
                        input logic try_write, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            loom_scan_enable = 1'b1;
            loom_scan_in     = in_bits[n-1-i];
            en_i    = try_write;
            we_i    = try_write;
            addr_i  = 2'd2;
            wdata_i = 8'h99;
            e.kind  = K_SCAN;
            e.value = {7'd0, out_bits[n-1-i]};
            e.name  = $sformatf("%s_bit%0d", name, i);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got 0x00, expected 0x01");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] init_vals [4];
        init_vals = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        rst_ni = 1'b1; en_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        loom_scan_enable = 1'b0; loom_scan_in = 1'b0;
        #1 rst_ni = 1'b0;
        #2;
        check("reset_rdata", rdata_o, 8'h00);
        check("reset_scan_out", {7'd0, loom_scan_out}, 8'h00);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        for (int a = 0; a < 4; a++) rd(2'(a), 8'h00, $sformatf("reset_read%0d", a));

        // Functional access
        for (int a = 0; a < 4; a++) wr(2'(a), init_vals[a]);
        rd(2'd1, 8'h3C, "func_read1");
        drive_idle();

        // Capture: stream out word0 MSB first, zeros shifted in
        scan(32, 64'h0, 64'hA53CFF01, 1'b0, "capture");
        drive_idle();
        for (int a = 0; a < 4; a++) rd(2'(a), 8'h00, $sformatf("capture_read%0d", a));
        drive_idle();

        // Restore: shift the captured stream back in
        scan(32, 64'hA53CFF01, 64'h0, 1'b0, "restore");
        drive_idle();
        for (int a = 0; a < 4; a++) rd(2'(a), init_vals[a], $sformatf("restore_read%0d", a));
        drive_idle();

        // Partial scan: one full word plus four bits of word 1
        scan(12, 64'h5AF, 64'hA53, 1'b0, "partial");
        drive_idle();
        rd(2'd0, 8'h5A, "partial_read0");
        rd(2'd1, 8'h3C, "partial_read1");
        rd(2'd2, 8'hFF, "partial_read2");
        rd(2'd3, 8'h01, "partial_read3");
        drive_idle();
        scan(8, 64'h5A, 64'h5A, 1'b0, "rescan");
        drive_idle();

        // Write to word 0 right before scan assertion is forwarded; writes during scan ignored
        wr(2'd0, 8'h77);
        scan(8, 64'h77, 64'h77, 1'b1, "fwd");
        drive_idle();
        rd(2'd2, 8'hFF, "ignored_write_read2");
        rd(2'd0, 8'h77, "fwd_read0");
        drive_idle();

        // Reset in the middle of a scan
        scan(5, 64'h1F, 64'h0E, 1'b0, "prereset");
        @(posedge clk_i); #1;
        rst_ni = 1'b0; loom_scan_enable = 1'b0; en_i = 1'b0; we_i = 1'b0;
        #1;
        check("midscan_reset_rdata", rdata_o, 8'h00);
        check("midscan_reset_scan_out", {7'd0, loom_scan_out}, 8'h00);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        scan(32, 64'hFFFFFFFF, 64'h0, 1'b0, "postreset");
        drive_idle();
        for (int a = 0; a < 4; a++) rd(2'(a), 8'hFF, $sformatf("postreset_read%0d", a));
        drive_idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
        repeat (2) @(negedge clk_i);
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loom_scan_mem.md
LOOM_SCAN_MEM -- requirements
Module: loom_scan_mem

Interface
REQ-001 Parameters SHALL be: Depth, default 4, number of words; Width, default 8, bits per word.
REQ-002 The chain length presented on the scan port SHALL be Depth*Width bits; both parameters SHALL be >=2.
REQ-003 clk_i, input, 1: single clock; all state SHALL be on its rising edge.
REQ-004 rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 en_i, input, 1: functional access request.
REQ-006 we_i, input, 1: write when en_i is high.
REQ-007 addr_i, input, $clog2(Depth): word address.
REQ-008 wdata_i, input, Width: write data.
REQ-009 rdata_o, output, Width: registered read data.
REQ-010 loom_scan_enable, input, 1: shift one chain bit per cycle while high.
REQ-011 loom_scan_in, input, 1: serial data in.
REQ-012 loom_scan_out, output, 1: serial data out.

Function
REQ-013 Storage SHALL be a Depth x Width register array mem.
REQ-014 Functional write: when en_i=1, we_i=1 and loom_scan_enable=0, mem[addr_i] SHALL take wdata_i at the next edge.
REQ-015 Functional read: when en_i=1, we_i=0 and loom_scan_enable=0, rdata_o SHALL show mem[addr_i] one cycle later; otherwise rdata_o holds its value.
REQ-016 While loom_scan_enable=1, en_i SHALL be ignored: no write, and rdata_o holds.
REQ-017 Internal state SHALL be: a Width-bit shift register sh, a bit counter bit_cnt (0..Width-1), and a word index word_idx (0..Depth-1).
REQ-018 loom_scan_out SHALL equal sh[Width-1] at all times (MSB-first).
REQ-019 Idle (loom_scan_enable=0): each cycle sh SHALL load mem[0], with bit_cnt=0 and word_idx=0.
REQ-020 Idle forwarding: if a functional write to address 0 occurs in the same cycle, sh SHALL load wdata_i instead of mem[0].
REQ-021 Shift (loom_scan_enable=1), each cycle: sh SHALL become {sh[Width-2:0], loom_scan_in} and bit_cnt SHALL increment.
REQ-022 Word boundary (bit_cnt=Width-1):
- mem[word_idx] SHALL be written with {sh[Width-2:0], loom_scan_in};
- sh SHALL load mem[(word_idx+1) mod Depth];
- bit_cnt SHALL return to 0;
- word_idx SHALL wrap from Depth-1 to 0.
REQ-023 Resulting chain order SHALL be: word 0 MSB first out, through word Depth-1 LSB last. A full Depth*Width shift with loom_scan_in fed the captured stream SHALL leave mem unchanged.
REQ-024 Shifting more than Depth*Width bits SHALL continue to rotate through words with no stall or error.
REQ-025 If loom_scan_enable deasserts mid-word:
- completed words SHALL remain written;
- the partial word SHALL be discarded, leaving its mem entry unchanged;
- the next cycle SHALL be idle per REQ-019.
REQ-026 A scan SHALL always begin at word 0 bit Width-1, regardless of how the previous scan ended.

Reset
REQ-027 While rst_ni=0, all of the following SHALL be 0 immediately, independent of clk_i: mem, sh, bit_cnt, word_idx, rdata_o, loom_scan_out.
REQ-028 Reset asserted mid-scan SHALL abort the scan; words already written keep no special status and are cleared per REQ-027.

Verification (Depth=4, Width=8)
REQ-029 Reset: hold rst_ni=0 -> rdata_o=0x00 and loom_scan_out=0; a read of any address returns 0x00.
REQ-030 Functional access: write 0xA5,0x3C,0xFF,0x01 to addresses 0..3, then read address 1 -> rdata_o=0x3C exactly one cycle later.
REQ-031 Capture: with the REQ-030 contents, assert scan 32 cycles with loom_scan_in=0.
- Out stream SHALL be 0xA53CFF01, MSB first.
- Afterwards all words read 0x00.
REQ-032 Restore: shift the captured 32 bits back in, then deassert -> reads return 0xA5,0x3C,0xFF,0x01.
REQ-033 Partial scan: scan 12 cycles with in-bits 0x5A then 0xF, then deassert.
- mem[0] reads 0x5A; mem[1..3] are unchanged.
- The next scan outputs 0x5A first.
REQ-034 Interactions:
- A write of 0x77 to address 0 in the cycle before scan assertion -> first 8 out bits are 0x77.
- A write to address 2 with en_i=1 during scan -> ignored.
- rst_ni pulsed low after 5 scan cycles -> all state 0; the next scan outputs all zeros.
